// File: rtl/cpu_cu_pkg.sv
// Shared types for the CPU control unit: FSM states, instruction classes, flag indices.
package cpu_cu_pkg;

  typedef enum logic [3:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_LDI,
    ST_LOAD,
    ST_STORE,
    ST_JUMP,
    ST_HALT,
    ST_ERR
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'b000,
    CLS_LDI   = 3'b001,
    CLS_LOAD  = 3'b010,
    CLS_STORE = 3'b011,
    CLS_JMP   = 3'b100,
    CLS_JZ    = 3'b101,
    CLS_JC    = 3'b110,
    CLS_HALT  = 3'b111
  } cls_t;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 0;

  // States that hold a memory request open until mem_rdy
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_LDI) || (s == ST_LOAD) || (s == ST_STORE);
  endfunction

endpackage

// File: rtl/cpu_cu_if.sv
// Control-unit bundle between the sequencer (master) and the execution unit / memory (slave).
interface cpu_cu_if;
  logic [15:0] ir;
  logic        n;
  logic        z;
  logic        c;
  logic        mem_rdy;
  logic        adr_sel;
  logic        s_sel;
  logic        pc_ld;
  logic        pc_inc;
  logic        reg_w_en;
  logic        ir_ld;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        halted;
  logic        bus_err;
  logic [2:0]  flags;

  modport master (
    input  ir, n, z, c, mem_rdy,
    output adr_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld,
           mem_r_en, mem_w_en, halted, bus_err, flags
  );

  modport slave (
    output ir, n, z, c, mem_rdy,
    input  adr_sel, s_sel, pc_ld, pc_inc, reg_w_en, ir_ld,
           mem_r_en, mem_w_en, halted, bus_err, flags
  );
endinterface

// File: rtl/cpu_cu_timeout.sv
// Memory wait counter: cleared on load, counts stalled cycles, flags when the limit is reached.
module cpu_cu_timeout #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_count,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_count && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the 16-bit CPU: fetch/decode/execute FSM with memory timeout.
module cpu_control_unit
  import cpu_cu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TO_W        = 8
) (
  input  logic          clk,
  input  logic          reset,
  cpu_cu_if.master      bus
);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_flags;
  cls_t       w_cls;
  logic       w_load;
  logic       w_count;
  logic       w_expired;

  logic w_adr_sel, w_s_sel, w_pc_ld, w_pc_inc, w_reg_w_en, w_ir_ld;
  logic w_mem_r_en, w_mem_w_en, w_halted;

  assign w_cls = cls_t'(bus.ir[11:9]);

  // Counter restarts whenever a memory state is freshly entered
  assign w_load  = is_mem_state(w_next) && (w_next != r_state);
  assign w_count = is_mem_state(r_state) && !bus.mem_rdy;

  cpu_cu_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_count   (w_count),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_RST;
      r_flags <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_EXEC) begin
        r_flags <= {bus.n, bus.z, bus.c};
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_adr_sel  = 1'b0;
    w_s_sel    = 1'b0;
    w_pc_ld    = 1'b0;
    w_pc_inc   = 1'b0;
    w_reg_w_en = 1'b0;
    w_ir_ld    = 1'b0;
    w_mem_r_en = 1'b0;
    w_mem_w_en = 1'b0;
    w_halted   = 1'b0;

    case (r_state)
      ST_RST: w_next = ST_FETCH;

      ST_FETCH: begin
        w_mem_r_en = 1'b1;
        if (bus.mem_rdy) begin
          w_ir_ld  = 1'b1;
          w_pc_inc = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end

      ST_DECODE: begin
        case (w_cls)
          CLS_ALU:   w_next = ST_EXEC;
          CLS_LDI:   w_next = ST_LDI;
          CLS_LOAD:  w_next = ST_LOAD;
          CLS_STORE: w_next = ST_STORE;
          CLS_JMP,
          CLS_JZ,
          CLS_JC:    w_next = ST_JUMP;
          CLS_HALT:  w_next = ST_HALT;
        endcase
      end

      ST_EXEC: begin
        w_reg_w_en = 1'b1;
        w_next     = ST_FETCH;
      end

      ST_LDI: begin
        w_s_sel    = 1'b1;
        w_mem_r_en = 1'b1;
        if (bus.mem_rdy) begin
          w_reg_w_en = 1'b1;
          w_pc_inc   = 1'b1;
          w_next     = ST_FETCH;
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end

      ST_LOAD: begin
        w_adr_sel  = 1'b1;
        w_s_sel    = 1'b1;
        w_mem_r_en = 1'b1;
        if (bus.mem_rdy) begin
          w_reg_w_en = 1'b1;
          w_next     = ST_FETCH;
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end

      ST_STORE: begin
        w_adr_sel  = 1'b1;
        w_mem_w_en = 1'b1;
        if (bus.mem_rdy) begin
          w_next = ST_FETCH;
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end

      ST_JUMP: begin
        case (w_cls)
          CLS_JMP: w_pc_ld = 1'b1;
          CLS_JZ:  w_pc_ld = r_flags[FLAG_Z];
          CLS_JC:  w_pc_ld = r_flags[FLAG_C];
          default: w_pc_ld = 1'b0;
        endcase
        w_next = ST_FETCH;
      end

      ST_HALT: w_halted = 1'b1;

      ST_ERR:  w_halted = 1'b1;

      default: w_next = ST_RST;
    endcase
  end

  assign bus.adr_sel  = w_adr_sel;
  assign bus.s_sel    = w_s_sel;
  assign bus.pc_ld    = w_pc_ld;
  assign bus.pc_inc   = w_pc_inc;
  assign bus.reg_w_en = w_reg_w_en;
  assign bus.ir_ld    = w_ir_ld;
  assign bus.mem_r_en = w_mem_r_en;
  assign bus.mem_w_en = w_mem_w_en;
  assign bus.halted   = w_halted;
  assign bus.bus_err  = (r_state == ST_ERR);
  assign bus.flags    = r_flags;

endmodule
